// File: rtl/traffic_src_mc_pkg.sv
// Shared types for the NoC traffic source: config opcodes, descriptor layout
// at the default field widths, and the playback FSM states.
package noc_traffic_pkg;

  localparam int DEF_DST_W   = 14;
  localparam int DEF_VC_W    = 2;
  localparam int DEF_NFLIT_W = 10;
  localparam int DEF_GAP_W   = 8;
  localparam int DEF_DESC_W  = DEF_DST_W + DEF_VC_W + DEF_NFLIT_W + DEF_GAP_W;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_FILL  = 3'd1,
    OP_START = 3'd2,
    OP_STOP  = 3'd3,
    OP_CLEAR = 3'd4
  } cfg_op_e;

  typedef struct packed {
    logic [DEF_GAP_W-1:0]   gap;
    logic [DEF_NFLIT_W-1:0] num_flits;
    logic [DEF_VC_W-1:0]    vc;
    logic [DEF_DST_W-1:0]   dst;
  } traffic_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } traffic_state_e;

  function automatic traffic_desc_t make_desc(
    input logic [DEF_DST_W-1:0]   dst,
    input logic [DEF_VC_W-1:0]    vc,
    input logic [DEF_NFLIT_W-1:0] num_flits,
    input logic [DEF_GAP_W-1:0]   gap
  );
    traffic_desc_t d;
    d.dst       = dst;
    d.vc        = vc;
    d.num_flits = num_flits;
    d.gap       = gap;
    return d;
  endfunction

endpackage

// File: rtl/traffic_src_mc_if.sv
// Flit link between the traffic source (master) and the router injection port (slave).
interface traffic_src_mc_if #(
  parameter int DST_W   = 14,
  parameter int VC_W    = 2,
  parameter int NFLIT_W = 10
);

  logic               flit_valid;
  logic               flit_ready;
  logic               flit_head;
  logic               flit_tail;
  logic [DST_W-1:0]   flit_dst;
  logic [VC_W-1:0]    flit_vc;
  logic [NFLIT_W-1:0] flit_idx;

  modport master (
    output flit_valid, flit_head, flit_tail, flit_dst, flit_vc, flit_idx,
    input  flit_ready
  );

  modport slave (
    input  flit_valid, flit_head, flit_tail, flit_dst, flit_vc, flit_idx,
    output flit_ready
  );

endinterface

// File: rtl/traffic_src_mc_desc_ram.sv
// Descriptor store: one write port, one synchronous read port. Contents are
// not reset.
module traffic_desc_ram #(
  parameter  int DEPTH = 1024,
  parameter  int W     = 34,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/traffic_src_mc.sv
// Descriptor-driven NoC traffic source: replays stored packets as a flit
// stream with per-packet gaps, optional looping and graceful stop.
module traffic_src_mc
  import noc_traffic_pkg::*;
#(
  parameter  int DEPTH   = 1024,
  parameter  int DST_W   = 14,
  parameter  int VC_W    = 2,
  parameter  int NFLIT_W = 10,
  parameter  int GAP_W   = 8,
  parameter  int CNT_W   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int DESC_W  = DST_W + VC_W + NFLIT_W + GAP_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             cfg_op_i,
  input  logic [DESC_W-1:0]      cfg_data_i,
  traffic_src_mc_if.master       flit,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       pkt_cnt_o
);

  typedef struct packed {
    logic [GAP_W-1:0]   gap;
    logic [NFLIT_W-1:0] num_flits;
    logic [VC_W-1:0]    vc;
    logic [DST_W-1:0]   dst;
  } desc_t;

  cfg_op_e            op;
  traffic_state_e     state_q;
  logic [AW:0]        count_q;
  logic [AW-1:0]      head_q;
  logic               loop_q;
  logic               stop_q;
  logic [NFLIT_W-1:0] flits_left_q;
  logic [GAP_W-1:0]   gap_left_q;
  logic [GAP_W-1:0]   gap_q;
  logic               valid_q;
  logic               fhead_q;
  logic               ftail_q;
  logic [DST_W-1:0]   dst_q;
  logic [VC_W-1:0]    vc_q;
  logic [NFLIT_W-1:0] idx_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   pkt_cnt_q;

  logic [DESC_W-1:0]  rd_data;
  desc_t              rd_desc;
  logic               idle_like;
  logic               fire;
  logic               tail_fire;
  logic               last_desc;
  logic               end_pkt;
  logic               wr_en;
  logic [AW-1:0]      last_idx;
  logic [AW-1:0]      head_d;
  logic [AW-1:0]      rd_addr;
  logic [NFLIT_W-1:0] nf_load;

  assign op        = cfg_op_e'(cfg_op_i);
  assign rd_desc   = desc_t'(rd_data);
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign fire      = valid_q & flit.flit_ready;
  assign tail_fire = (state_q == ST_SEND) & fire & ftail_q;
  assign last_idx  = AW'(count_q - 1'b1);
  assign last_desc = (head_q == last_idx);
  assign head_d    = last_desc ? '0 : head_q + 1'b1;
  assign end_pkt   = stop_q | (op == OP_STOP) | (last_desc & ~loop_q);
  // DEPTH is a power of two, so the count MSB alone means "full".
  assign wr_en     = (op == OP_FILL) & idle_like & ~count_q[AW];
  assign nf_load   = (rd_desc.num_flits == '0) ? NFLIT_W'(1) : rd_desc.num_flits;

  // Read address always points at the descriptor the next LOAD will consume,
  // so the synchronous read data is already valid throughout LOAD.
  assign rd_addr = idle_like ? '0 : (tail_fire ? head_d : head_q);

  traffic_desc_ram #(
    .DEPTH (DEPTH),
    .W     (DESC_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (count_q[AW-1:0]),
    .wr_data_i (cfg_data_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      head_q       <= '0;
      loop_q       <= 1'b0;
      stop_q       <= 1'b0;
      flits_left_q <= '0;
      gap_left_q   <= '0;
      gap_q        <= '0;
      valid_q      <= 1'b0;
      fhead_q      <= 1'b0;
      ftail_q      <= 1'b0;
      dst_q        <= '0;
      vc_q         <= '0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
      pkt_cnt_q    <= '0;
    end else if (op == OP_CLEAR) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      valid_q    <= 1'b0;
      fhead_q    <= 1'b0;
      ftail_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        count_q <= count_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if ((op == OP_FILL) && count_q[AW]) begin
            overflow_q <= 1'b1;
          end
          if (op == OP_START) begin
            if (count_q != '0) begin
              head_q    <= '0;
              loop_q    <= cfg_data_i[0];
              pkt_cnt_q <= '0;
              stop_q    <= 1'b0;
              state_q   <= ST_LOAD;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (op == OP_STOP) begin
            stop_q <= 1'b1;
          end
          dst_q        <= rd_desc.dst;
          vc_q         <= rd_desc.vc;
          gap_q        <= rd_desc.gap;
          flits_left_q <= nf_load;
          idx_q        <= '0;
          valid_q      <= 1'b1;
          fhead_q      <= 1'b1;
          ftail_q      <= (nf_load == NFLIT_W'(1));
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (op == OP_STOP) begin
            stop_q <= 1'b1;
          end
          if (fire && ftail_q) begin
            valid_q <= 1'b0;
            fhead_q <= 1'b0;
            ftail_q <= 1'b0;
            head_q  <= head_d;
            if (pkt_cnt_q != '1) begin
              pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
            if (end_pkt) begin
              state_q <= ST_DONE;
            end else if (gap_q != '0) begin
              gap_left_q <= gap_q;
              state_q    <= ST_GAP;
            end else begin
              state_q <= ST_LOAD;
            end
          end else if (fire) begin
            idx_q        <= idx_q + 1'b1;
            flits_left_q <= flits_left_q - 1'b1;
            fhead_q      <= 1'b0;
            ftail_q      <= (flits_left_q == NFLIT_W'(2));
          end
        end
        ST_GAP: begin
          if (op == OP_STOP) begin
            state_q <= ST_DONE;
          end else if (gap_left_q == GAP_W'(1)) begin
            state_q <= ST_LOAD;
          end else begin
            gap_left_q <= gap_left_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flit.flit_valid = valid_q;
  assign flit.flit_head  = fhead_q;
  assign flit.flit_tail  = ftail_q;
  assign flit.flit_dst   = dst_q;
  assign flit.flit_vc    = vc_q;
  assign flit.flit_idx   = idx_q;
  assign busy_o          = ~idle_like;
  assign done_o          = (state_q == ST_DONE);
  assign overflow_o      = overflow_q;
  assign pkt_cnt_o       = pkt_cnt_q;

endmodule

// File: tb/tb_traffic_src_mc.sv
// Directed bench for traffic_src_mc: playback order/timing, back-pressure,
// looped stop, overflow/clear, zero-flit and empty starts, async reset.
module tb_traffic_src_mc;
  import noc_traffic_pkg::*;

  localparam int DEPTH = 4;
  localparam int PK_W  = 2 + DEF_DST_W + DEF_VC_W + DEF_NFLIT_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [2:0]            cfg_op;
  logic [DEF_DESC_W-1:0] cfg_data;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [15:0]           pkt_cnt;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int startCyc;
  int accCyc[$];
  logic [PK_W-1:0] expFlit[$];

  traffic_src_mc_if #(
    .DST_W   (DEF_DST_W),
    .VC_W    (DEF_VC_W),
    .NFLIT_W (DEF_NFLIT_W)
  ) lnk ();

  traffic_src_mc #(
    .DEPTH   (DEPTH),
    .DST_W   (DEF_DST_W),
    .VC_W    (DEF_VC_W),
    .NFLIT_W (DEF_NFLIT_W),
    .GAP_W   (DEF_GAP_W),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_op_i   (cfg_op),
    .cfg_data_i (cfg_data),
    .flit       (lnk),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (overflow),
    .pkt_cnt_o  (pkt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PK_W-1:0] pk(input logic h, input logic t,
                                         input logic [DEF_DST_W-1:0] dst,
                                         input logic [DEF_VC_W-1:0] vc,
                                         input logic [DEF_NFLIT_W-1:0] idx);
    return {h, t, dst, vc, idx};
  endfunction

  function automatic logic [PK_W-1:0] obsFlit();
    return pk(lnk.flit_head, lnk.flit_tail, lnk.flit_dst, lnk.flit_vc, lnk.flit_idx);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [DEF_DESC_W-1:0] data);
    cfg_op   = op;
    cfg_data = data;
    nextCycle();
    cfg_op   = OP_NOP;
  endtask

  task automatic fillThree();
    applyStimulus(OP_FILL, make_desc(14'd5, 2'd1, 10'd3, 8'd0));
    applyStimulus(OP_FILL, make_desc(14'd9, 2'd0, 10'd1, 8'd2));
    applyStimulus(OP_FILL, make_desc(14'd2, 2'd3, 10'd2, 8'd0));
  endtask

  task automatic loadExpThree();
    expFlit.push_back(pk(1'b1, 1'b0, 14'd5, 2'd1, 10'd0));
    expFlit.push_back(pk(1'b0, 1'b0, 14'd5, 2'd1, 10'd1));
    expFlit.push_back(pk(1'b0, 1'b1, 14'd5, 2'd1, 10'd2));
    expFlit.push_back(pk(1'b1, 1'b1, 14'd9, 2'd0, 10'd0));
    expFlit.push_back(pk(1'b1, 1'b0, 14'd2, 2'd3, 10'd0));
    expFlit.push_back(pk(1'b0, 1'b1, 14'd2, 2'd3, 10'd1));
  endtask

  // Watches the link until done; every presented flit (stalled or not) must
  // equal the next expected one, which also proves stability under stall.
  task automatic runStream(input string tag, input int stopAt, input bit toggle);
    int  k;
    int  lastAcc;
    bit  stopSent;
    bit  finished;
    k        = 0;
    lastAcc  = -1;
    stopSent = 1'b0;
    finished = 1'b0;
    accCyc.delete();
    for (int n = 0; n < 200 && !finished; n++) begin
      lnk.flit_ready = toggle ? ((n % 2) == 0) : 1'b1;
      if (stopAt >= 0 && k == stopAt && !stopSent) begin
        cfg_op   = OP_STOP;
        stopSent = 1'b1;
      end else begin
        cfg_op = OP_NOP;
      end
      if (done) begin
        finished = 1'b1;
        checkOutput({tag, "_done_lat"}, 64'(cyc - lastAcc), 64'd1);
      end else if (lnk.flit_valid) begin
        if (k < expFlit.size()) begin
          checkOutput({tag, "_flit"}, 64'(obsFlit()), 64'(expFlit[k]));
        end else begin
          checkOutput({tag, "_extra_flit"}, 64'(k), 64'(expFlit.size()));
        end
        if (lnk.flit_ready) begin
          accCyc.push_back(cyc);
          lastAcc = cyc;
          k++;
        end
      end
      if (!finished) nextCycle();
    end
    cfg_op = OP_NOP;
    checkOutput({tag, "_finished"}, 64'(finished), 64'd1);
    checkOutput({tag, "_nflits"}, 64'(k), 64'(expFlit.size()));
  endtask

  initial begin
    rst_n          = 1'b0;
    cfg_op         = OP_NOP;
    cfg_data       = '0;
    lnk.flit_ready = 1'b0;
    #12;
    checkOutput("rst_valid", 64'(lnk.flit_valid), 64'd0);
    checkOutput("rst_flit", 64'(obsFlit()), 64'd0);
    checkOutput("rst_status", 64'({busy, done, overflow}), 64'd0);
    checkOutput("rst_pktcnt", 64'(pkt_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] basic playback, ready=1");
    fillThree();
    expFlit.delete();
    loadExpThree();
    startCyc = cyc;
    applyStimulus(OP_START, '0);
    runStream("basic", -1, 1'b0);
    if (accCyc.size() >= 5) begin
      checkOutput("first_head_lat", 64'(accCyc[0] - startCyc), 64'd2);
      checkOutput("gap0_head_lat", 64'(accCyc[3] - accCyc[2]), 64'd2);
      checkOutput("gap2_head_lat", 64'(accCyc[4] - accCyc[3]), 64'd4);
    end else begin
      checkOutput("basic_acc_count", 64'(accCyc.size()), 64'd6);
    end
    checkOutput("basic_pktcnt", 64'(pkt_cnt), 64'd3);
    checkOutput("basic_busy", 64'(busy), 64'd0);

    $display("[TB] replay with ready toggling");
    applyStimulus(OP_START, '0);
    runStream("stall", -1, 1'b1);
    checkOutput("stall_pktcnt", 64'(pkt_cnt), 64'd3);

    $display("[TB] looped playback with stop");
    lnk.flit_ready = 1'b1;
    expFlit.delete();
    loadExpThree();
    expFlit.push_back(pk(1'b1, 1'b0, 14'd5, 2'd1, 10'd0));
    expFlit.push_back(pk(1'b0, 1'b0, 14'd5, 2'd1, 10'd1));
    expFlit.push_back(pk(1'b0, 1'b1, 14'd5, 2'd1, 10'd2));
    applyStimulus(OP_START, DEF_DESC_W'(1));
    runStream("loop", 7, 1'b0);
    checkOutput("loop_pktcnt", 64'(pkt_cnt), 64'd4);

    $display("[TB] overflow and clear");
    applyStimulus(OP_CLEAR, '0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_FILL, make_desc(14'(10 + i), 2'(i), 10'd1, 8'd0));
    end
    checkOutput("full_no_ovf", 64'(overflow), 64'd0);
    applyStimulus(OP_FILL, make_desc(14'd14, 2'd0, 10'd1, 8'd0));
    checkOutput("ovf_set", 64'(overflow), 64'd1);
    expFlit.delete();
    for (int i = 0; i < DEPTH; i++) begin
      expFlit.push_back(pk(1'b1, 1'b1, 14'(10 + i), 2'(i), 10'd0));
    end
    applyStimulus(OP_START, '0);
    runStream("full", -1, 1'b0);
    checkOutput("full_pktcnt", 64'(pkt_cnt), 64'(DEPTH));
    applyStimulus(OP_CLEAR, '0);
    checkOutput("clr_ovf", 64'(overflow), 64'd0);
    checkOutput("clr_idle", 64'({busy, done}), 64'd0);
    applyStimulus(OP_START, '0);
    checkOutput("empty_done", 64'(done), 64'd1);
    checkOutput("empty_valid", 64'(lnk.flit_valid), 64'd0);

    $display("[TB] zero-flit descriptor");
    applyStimulus(OP_CLEAR, '0);
    applyStimulus(OP_FILL, make_desc(14'd7, 2'd2, 10'd0, 8'd0));
    expFlit.delete();
    expFlit.push_back(pk(1'b1, 1'b1, 14'd7, 2'd2, 10'd0));
    applyStimulus(OP_START, '0);
    runStream("nf0", -1, 1'b0);
    checkOutput("nf0_pktcnt", 64'(pkt_cnt), 64'd1);

    $display("[TB] reset mid-packet");
    applyStimulus(OP_CLEAR, '0);
    fillThree();
    applyStimulus(OP_START, '0);
    nextCycle();
    checkOutput("pre_rst_valid", 64'(lnk.flit_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(lnk.flit_valid), 64'd0);
    checkOutput("arst_flit", 64'(obsFlit()), 64'd0);
    checkOutput("arst_status", 64'({busy, done, overflow}), 64'd0);
    checkOutput("arst_pktcnt", 64'(pkt_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(OP_START, '0);
    checkOutput("post_rst_done", 64'(done), 64'd1);
    nextCycle();
    checkOutput("post_rst_valid", 64'(lnk.flit_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
